hazard_ctrl: RTL

//  Pipeline hazard and stall sequencer for the 5-stage RV32I core. Drives the stall and clear inputs of
//  PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus the EX-stage forwarding selects.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/stall sequencer: FSM state codes,
// forwarding-select encodings and a counter-width helper.
package hazard_pkg;

   // FSM state codes
   localparam logic [1:0] ST_INIT     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;
   localparam logic [1:0] ST_ERROR    = 2'd3;

   // EX-stage operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // One counter serves both the reset flush and the memory wait, so it is
   // sized for whichever limit is larger.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand-source select for one EX-stage operand. MEM result wins over WB
// result; x0 never forwards because it is hardwired to zero.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] src_addr_i,
   input  logic [4:0] rd_m_i,
   input  logic       regwrite_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       regwrite_w_i,
   output logic [1:0] fwd_o
);

   // Priority select: MEM, then WB, else register file
   always_comb begin
      fwd_o = FWD_RF;
      if (regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == src_addr_i))
         fwd_o = FWD_MEM;
      else if (regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == src_addr_i))
         fwd_o = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline: reset flush,
// load-use stall, branch squash, data-memory wait stall and wait timeout.
// Optional build macro HAZ_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int INIT_FLUSH  = 2,
   parameter int MEM_TIMEOUT = 256,
   parameter int PERF_W      = 32
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [4:0] RS_addr_D,
   input  logic [4:0] RT_addr_D,
   input  logic [4:0] RS_addr_E,
   input  logic [4:0] RT_addr_E,
   input  logic [4:0] RD_addr_E,
   input  logic [3:0] MemRead_E,
   input  logic [4:0] RD_addr_M,
   input  logic       RegWrite_M,
   input  logic [4:0] RD_addr_W,
   input  logic       RegWrite_W,
   input  logic       PCSrc_E,
   input  logic       dmem_req_M,
   input  logic       dmem_ready,
   output logic       Stall_F,
   output logic       Stall_D,
   output logic       Stall_E,
   output logic       Stall_M,
   output logic       Flush_D,
   output logic       Flush_E,
   output logic       Flush_W,
   output logic [1:0] Fwd1_E,
   output logic [1:0] Fwd2_E,
   output logic       mem_err
`ifdef HAZ_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   localparam int CNT_W = cnt_width(INIT_FLUSH, MEM_TIMEOUT);

   if (INIT_FLUSH < 1 || MEM_TIMEOUT < 2 || PERF_W < 1) begin : g_bad_cfg
      $error("hazard_ctrl: INIT_FLUSH>=1, MEM_TIMEOUT>=2, PERF_W>=1 required");
   end

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;

   logic             mem_wait;
   logic             load_use;
   logic             stall_all;   // freeze F/D/E/M and bubble into MEM_WB
   logic             stall_fd;    // load-use hold of PC and IF_ID
   logic             flush_de;    // clear IF_ID and ID_EX
   logic             flush_lu;    // bubble into ID_EX behind a load
   logic [1:0]       fwd1, fwd2;

   assign mem_wait = dmem_req_M & ~dmem_ready;
   assign load_use = (|MemRead_E) && (RD_addr_E != 5'd0) &&
                     ((RD_addr_E == RS_addr_D) || (RD_addr_E == RT_addr_D));

   hazard_fwd_sel u_fwd_rs (
      .src_addr_i   (RS_addr_E),
      .rd_m_i       (RD_addr_M),
      .regwrite_m_i (RegWrite_M),
      .rd_w_i       (RD_addr_W),
      .regwrite_w_i (RegWrite_W),
      .fwd_o        (fwd1)
   );

   hazard_fwd_sel u_fwd_rt (
      .src_addr_i   (RT_addr_E),
      .rd_m_i       (RD_addr_M),
      .regwrite_m_i (RegWrite_M),
      .rd_w_i       (RD_addr_W),
      .regwrite_w_i (RegWrite_W),
      .fwd_o        (fwd2)
   );

   // Next state and hazard responses; a memory wait masks branch and load-use
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      stall_all = 1'b0;
      stall_fd  = 1'b0;
      flush_de  = 1'b0;
      flush_lu  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            flush_de = 1'b1;
            if (cnt_q == CNT_W'(INIT_FLUSH - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (mem_wait) begin
               stall_all = 1'b1;
               state_d   = ST_MEM_WAIT;
               cnt_d     = '0;
            end else if (PCSrc_E) begin
               // squash the younger instruction, even if it was load-use stalled
               flush_de = 1'b1;
            end else if (load_use) begin
               stall_fd = 1'b1;
               flush_lu = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               stall_all = 1'b1;
               if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                  state_d   = ST_ERROR;
                  mem_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            // ERROR: frozen until reset, dmem_ready no longer matters
            stall_all = 1'b1;
         end
      endcase
   end

   // State, counter and sticky error flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= ST_INIT;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign Stall_F = stall_all | stall_fd;
   assign Stall_D = stall_all | stall_fd;
   assign Stall_E = stall_all;
   assign Stall_M = stall_all;
   assign Flush_W = stall_all;
   assign Flush_D = flush_de;
   assign Flush_E = flush_de | flush_lu;
   assign mem_err = mem_err_q;
   // Selects are forced to the register file while reset is held
   assign Fwd1_E  = nRST ? fwd1 : FWD_RF;
   assign Fwd2_E  = nRST ? fwd2 : FWD_RF;

`ifdef HAZ_PERF_EN
   logic [PERF_W-1:0] perf_stall_q;
   logic [PERF_W-1:0] perf_flush_q;
   logic              br_flush;

   assign br_flush = (state_q == ST_RUN) && !mem_wait && PCSrc_E;

   // Saturating counts of PC-hold cycles and branch flushes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (Stall_F && !(&perf_stall_q))
            perf_stall_q <= perf_stall_q + PERF_W'(1);
         if (br_flush && !(&perf_flush_q))
            perf_flush_q <= perf_flush_q + PERF_W'(1);
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
